// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine.
// A captured block is transformed LANES columns per cycle into the result
// register, then held on out_data until the consumer takes it.
module mix_columns_engine #(
    parameter int unsigned NB    = 4,
    parameter int unsigned LANES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [32*NB-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              busy
);

    localparam int unsigned CW = $clog2(NB + 1);

    generate
        if ((NB != 4 && NB != 6 && NB != 8) || LANES == 0 || (NB % LANES) != 0) begin : g_cfg_err
            $error("mix_columns_engine: NB must be 4, 6 or 8 and LANES must divide NB");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [32*NB-1:0]  src_q, src_d;
    logic [32*NB-1:0]  res_q, res_d;
    logic              inv_q, inv_d;
    logic              arm_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // One column; k[n][j] is row byte j scaled by the n-th coefficient of the mode.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a, p2, p4, p8, acc;
        logic [7:0] k [4][4];
        logic [31:0] r;
        for (int unsigned j = 0; j < 4; j++) begin
            a  = col[31-8*j -: 8];
            p2 = xtime(a);
            p4 = xtime(p2);
            p8 = xtime(p4);
            if (inv) begin
                k[0][j] = p8 ^ p4 ^ p2;
                k[1][j] = p8 ^ p2 ^ a;
                k[2][j] = p8 ^ p4 ^ a;
                k[3][j] = p8 ^ a;
            end else begin
                k[0][j] = p2;
                k[1][j] = p2 ^ a;
                k[2][j] = a;
                k[3][j] = a;
            end
        end
        r = '0;
        for (int unsigned row = 0; row < 4; row++) begin
            acc = '0;
            for (int unsigned j = 0; j < 4; j++) begin
                acc = acc ^ k[(j + 4 - row) % 4][j];
            end
            r[31-8*row -: 8] = acc;
        end
        return r;
    endfunction

    assign in_ready  = (state_q == IDLE) && arm_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = res_q;

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) arm_q <= 1'b0;
        else      arm_q <= 1'b1;
    end

    // State, counter and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
            inv_q   <= inv_d;
        end
    end

    // Next-state logic; each lane muxes its column in and its result back out.
    always_comb begin : p_next
        logic [31:0] lane_col;
        logic [31:0] lane_res;
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        res_d    = res_q;
        inv_d    = inv_q;
        lane_col = '0;
        lane_res = '0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    src_d   = in_data;
                    inv_d   = in_inv;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    lane_col = '0;
                    for (int unsigned c = 0; c < NB; c++) begin
                        if (32'(cnt_q) + l == c) lane_col = src_q[32*NB-1-32*c -: 32];
                    end
                    lane_res = mix_col(lane_col, inv_q);
                    for (int unsigned c = 0; c < NB; c++) begin
                        if (32'(cnt_q) + l == c) res_d[32*NB-1-32*c -: 32] = lane_res;
                    end
                end
                cnt_d = cnt_q + CW'(LANES);
                if (cnt_q == CW'(NB - LANES)) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench for mix_columns_engine (NB=4/LANES=1 and NB=8/LANES=2).
module tb_mix_columns_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_out_data;
    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_busy;
    logic [255:0] b_in_data, b_out_data;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    mix_columns_engine #(.NB(4), .LANES(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    mix_columns_engine #(.NB(8), .LANES(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // GF(2^8) product: carry-less multiply, then reduce by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product applied to every column of the block.
    function automatic logic [255:0] ref_block(input logic [255:0] d, input int nb, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   acc, bj;
        logic [255:0] o;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    bj  = 8'(d >> (32*nb - 8 - 32*c - 8*j));
                    acc = acc ^ gmul(coef[(j + 4 - r) % 4], bj);
                end
                o = o | (256'(acc) << (32*nb - 8 - 32*c - 8*r));
            end
        end
        return o;
    endfunction

    task automatic a_accept(input logic [127:0] d, input logic inv);
        int n = 0;
        while (!a_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("a_ready_timeout", {255'b0, a_in_ready}, 256'd1);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_inv   = inv;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_data  = {$urandom, $urandom, $urandom, $urandom};
        a_in_inv   = 1'($urandom);
    endtask

    // Waits for out_valid while toggling inputs that must be ignored during CALC.
    task automatic a_wait(output int n);
        n = 0;
        while (!a_out_valid && n < 50) begin
            a_out_ready = 1'($urandom);
            a_in_valid  = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
    endtask

    task automatic a_drain(input string tag);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk({tag, "_rdy_after"}, {255'b0, a_in_ready}, 256'd1);
        chk({tag, "_vld_after"}, {255'b0, a_out_valid}, 256'd0);
    endtask

    task automatic a_block(input logic [127:0] d, input logic inv, input string tag,
                           output logic [127:0] got);
        int n;
        logic [255:0] e;
        e = ref_block({128'b0, d}, 4, inv);
        a_accept(d, inv);
        a_wait(n);
        chk({tag, "_lat"}, 256'(n), 256'd4);
        chk({tag, "_data"}, {128'b0, a_out_data}, e);
        got = a_out_data;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            chk({tag, "_stall"}, {127'b0, a_out_valid, a_out_data}, {127'b0, 1'b1, got});
        end
        a_drain(tag);
    endtask

    task automatic b_block(input logic [255:0] d, input logic inv, input string tag,
                           output logic [255:0] got);
        int n = 0;
        logic [255:0] e;
        e = ref_block(d, 8, inv);
        while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_inv   = inv;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        b_in_inv   = ~inv;
        n = 0;
        while (!b_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"}, 256'(n), 256'd4);
        chk({tag, "_data"}, b_out_data, e);
        got = b_out_data;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk({tag, "_rdy_after"}, {255'b0, b_in_ready}, 256'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got, held, x, y, z;
        logic [255:0] gotb;
        logic         m;
        int           n;

        rst = 1'b0;
        a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = '1; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_a_outs", {124'b0, a_in_ready, a_out_valid, a_busy, 1'b0, a_out_data},
            256'd0);
        chk("rst_b_data", b_out_data, 256'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_hold", {124'b0, a_in_ready, a_out_valid, a_busy, 1'b0, a_out_data}, 256'd0);
        chk("rst_b_flags", {253'b0, b_in_ready, b_out_valid, b_busy}, 256'd0);
        a_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rdy_before_edge", {255'b0, a_in_ready}, 256'd0);
        @(posedge clk); #1;
        chk("rdy_after_edge_a", {255'b0, a_in_ready}, 256'd1);
        chk("rdy_after_edge_b", {255'b0, b_in_ready}, 256'd1);

        // Known forward and inverse vectors
        a_block(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, "fwd_vec", got);
        chk("fwd_vec_const", {128'b0, got}, {128'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6});
        a_block(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, "inv_vec", got);
        chk("inv_vec_const", {128'b0, got}, {128'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6});
        x = {32'hd4d4d4d5, 32'h2d26314c, $urandom, $urandom};
        a_block(x, 1'b0, "fwd_vec2", got);
        chk("fwd_d4", 256'(got[127:96]), 256'h d5d5d7d6);
        chk("fwd_2d", 256'(got[95:64]), 256'h4d7ebdf8);

        // Backpressure with a block offered during HOLD
        a_accept({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        a_wait(n);
        chk("bp_lat", 256'(n), 256'd4);
        held = a_out_data;
        a_in_valid = 1'b1;
        a_in_data  = {$urandom, $urandom, $urandom, $urandom};
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_stable", {125'b0, a_out_valid, a_in_ready, a_busy, a_out_data},
                {125'b0, 1'b1, 1'b0, 1'b1, held});
        end
        a_drain("bp");
        a_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, "bp_next", got);

        // Reset after two CALC cycles
        a_accept({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", {255'b0, a_busy}, 256'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_outs", {124'b0, a_in_ready, a_out_valid, a_busy, 1'b0, a_out_data}, 256'd0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("mid_rst_novld", {254'b0, a_out_valid, a_busy}, 256'd0);
        end
        rst = 1'b1;
        a_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), "post_rst", got);

        // Two-lane, eight-column instance
        b_block({2{128'hdb135345_f20a225c_01010101_c6c6c6c6}}, 1'b0, "b_fwd", gotb);
        chk("b_fwd_const", gotb, {2{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6}});
        b_block({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                1'b1, "b_inv_rand", gotb);

        // Randomised round trips
        for (int i = 0; i < 1000; i++) begin
            m = 1'($urandom);
            x = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            a_block(x, m, "rt_a", y);
            a_block(y, ~m, "rt_b", z);
            chk("rt_round", {128'b0, z}, {128'b0, x});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 Parameter NB, default 4: state columns per block, 32 bits each; legal values 4, 6, 8.
REQ-002 Parameter LANES, default 1: columns processed per cycle; must divide NB; a non-divisor is a configuration error.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 in_valid  input  1  input block offered.
REQ-006 in_ready  output  1  block accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-007 in_inv  input  1  mode, sampled with the block: 0 = MixColumns, 1 = InvMixColumns.
REQ-008 in_data  input  32*NB  state; column c occupies bits [32*NB-1-32c -: 32]; row 0 is the most significant byte of each column.
REQ-009 out_valid  output  1  result held on out_data.
REQ-010 out_ready  input  1  consumer takes the result when out_valid and out_ready are both 1 at a rising edge.
REQ-011 out_data  output  32*NB  transformed state, same packing as in_data.
REQ-012 busy  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-013 FSM states: IDLE, CALC, HOLD; in_ready = (state==IDLE); out_valid = (state==HOLD).
REQ-014 IDLE -> CALC on an input handshake: capture in_data into the source register, in_inv into the mode register, clear the column counter.
REQ-015 CALC: each cycle, transform columns cnt..cnt+LANES-1 into the result register; cnt advances by LANES.
REQ-016 CALC -> HOLD on the cycle that processes the last column group; no pipeline bubble.
REQ-017 Latency: handshake at edge k gives out_valid=1 after edge k+NB/LANES (default: edge k+4).
REQ-018 HOLD -> IDLE on an output handshake; out_data and out_valid are stable while out_ready=0.
REQ-019 Back-to-back blocks: in_ready rises the cycle after the output handshake; per-block throughput is NB/LANES+2 cycles.
REQ-020 Forward column map: r0'=2a^3b^c^d, r1'=a^2b^3c^d, r2'=a^b^2c^3d, r3'=3a^b^c^2d, where a..d are rows 0..3.
REQ-021 Inverse map: coefficients {0e,0b,0d,09}, rotated per row the same way.
REQ-022 Arithmetic is GF(2^8) with reduction polynomial 0x11B.
REQ-023 xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0).
REQ-024 Products are built from xtime chains only; no lookup tables; every intermediate value is 8 bits wide.
REQ-025 in_data and in_inv are ignored outside IDLE; changing them during CALC has no effect on the result.
REQ-026 out_ready is ignored outside HOLD.
REQ-027 out_data shows the result register at all times; its content outside HOLD is unspecified to the consumer.

Reset
REQ-028 While rst=0: state=IDLE, counter=0, source/result/mode registers=0.
REQ-029 While rst=0, outputs are in_ready=0, out_valid=0, busy=0, out_data=0.
REQ-030 in_ready rises on the first rising edge after rst returns to 1.
REQ-031 Reset asserted in CALC or HOLD abandons the block immediately; no partial result is ever flagged valid.

Verification
REQ-032 NB=4, LANES=1, fwd: column 0 = db135345, columns 1..3 = f20a225c, 01010101, c6c6c6c6 -> out 8e4da1bc 9fdc589d 01010101 c6c6c6c6, out_valid exactly 4 edges after accept.
REQ-033 Inverse of REQ-032: in_inv=1 with 8e4da1bc 9fdc589d 01010101 c6c6c6c6 -> db135345 f20a225c 01010101 c6c6c6c6; also forward d4d4d4d5 -> d5d5d7d6 and 2d26314c -> 4d7ebdf8.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles -> out_data constant, in_ready=0, busy=1; release -> IDLE next cycle, second block accepted.
REQ-035 Reset mid-CALC: drop rst after 2 CALC cycles -> all outputs 0 asynchronously, no out_valid; next block is processed correctly.
REQ-036 NB=8, LANES=2: 8-column block of REQ-032 columns repeated twice -> same results per column, latency 4 edges.
REQ-037 Random regression: 1000 blocks, random modes, randomly gated in_valid/out_ready -> forward-then-inverse round trip returns the original block, no block lost or duplicated.
